// File: rtl/la_pkg.sv
// Shared constants and types for the logic-analyser capture packer.
package la_pkg;

  localparam int unsigned RECORD_BITS = 64;
  localparam int unsigned LANES       = 4;
  localparam int unsigned WORD_BITS   = RECORD_BITS * LANES;

  // An all-zero record never comes from the datapath, so it marks unused lanes.
  localparam logic [RECORD_BITS-1:0] PAD_RECORD = '0;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StTriggered,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/la_word_accumulator.sv
// Collects 64-bit records into a 256-bit word, lane 0 first.
// Lane 3 is never stored: the record that fills it completes the word combinationally.
module la_word_accumulator
  import la_pkg::*;
(
  input  logic                   clk_400mhz,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   take,
  input  logic [RECORD_BITS-1:0] rec,
  output logic [1:0]             fill,
  output logic                   complete,
  output logic [WORD_BITS-1:0]   word
);

  localparam int StoredLanes = int'(LANES) - 1;

  logic [RECORD_BITS-1:0] lane_q [StoredLanes];
  logic [1:0]             fill_q;

  assign fill     = fill_q;
  assign complete = push && (fill_q == 2'd3);

  // Word as it would leave now: stored lanes, the incoming record in the next lane, pad above.
  always_comb begin
    word = '0;
    for (int k = 0; k < StoredLanes; k++) begin
      if (k < int'(fill_q)) begin
        word[k*RECORD_BITS +: RECORD_BITS] = lane_q[k];
      end else if ((k == int'(fill_q)) && push) begin
        word[k*RECORD_BITS +: RECORD_BITS] = rec;
      end else begin
        word[k*RECORD_BITS +: RECORD_BITS] = PAD_RECORD;
      end
    end
    word[StoredLanes*RECORD_BITS +: RECORD_BITS] = complete ? rec : PAD_RECORD;
  end

  // Fill bookkeeping; a completing record that is not taken is dropped and the 3 lanes stay.
  always_ff @(posedge clk_400mhz or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int k = 0; k < StoredLanes; k++) lane_q[k] <= '0;
    end else if (clear || take) begin
      fill_q <= '0;
    end else if (push && !complete) begin
      fill_q <= fill_q + 2'd1;
      for (int k = 0; k < StoredLanes; k++) begin
        if (fill_q == 2'(k)) lane_q[k] <= rec;
      end
    end
  end

endmodule

// File: rtl/la_capture_packer.sv
// Packs pod records into DRAM words written around a circular capture ring, with
// arm/trigger/post-trigger control and trigger-position, wrap and overflow status.
module la_capture_packer
  import la_pkg::*;
#(
  parameter int unsigned RING_BITS = 20,
  parameter int unsigned PTW_BITS  = 20
) (
  input  logic                   clk_400mhz,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [RECORD_BITS-1:0] in_data,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trigger,
  input  logic [PTW_BITS-1:0]    post_trig_words,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [RING_BITS-1:0]   wr_addr,
  output logic [WORD_BITS-1:0]   wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [RING_BITS-1:0]   trig_addr,
  output logic [1:0]             trig_lane,
  output logic                   wrapped,
  output logic                   overflow
);

  state_e              state_q;
  logic [PTW_BITS-1:0] ptw_q;
  logic [PTW_BITS-1:0] cnt_q;
  logic                pend_q;  // word holding the trigger record has not reached the register yet

  logic                 live;
  logic                 push;
  logic                 hs;
  logic                 reg_free;
  logic                 flush_load;
  logic                 load;
  logic                 drop;
  logic [1:0]           fill;
  logic                 complete;
  logic [WORD_BITS-1:0] acc_word;

  assign live       = (state_q == StArmed) || (state_q == StTriggered);
  assign push       = live && in_valid && !abort;
  assign hs         = wr_valid && wr_ready;
  assign reg_free   = !wr_valid || wr_ready;
  assign flush_load = (state_q == StFlush) && (fill != 2'd0) && reg_free && !abort;
  assign load       = (complete && reg_free) || flush_load;
  assign drop       = complete && !reg_free;

  assign busy = live || (state_q == StFlush);
  assign done = (state_q == StDone);

  la_word_accumulator u_acc (
    .clk_400mhz (clk_400mhz),
    .rst_n      (rst_n),
    .clear      (abort),
    .push       (push),
    .take       (load),
    .rec        (in_data),
    .fill       (fill),
    .complete   (complete),
    .word       (acc_word)
  );

  // Capture FSM, output register, ring addressing and sticky status.
  always_ff @(posedge clk_400mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptw_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      trig_addr <= '0;
      trig_lane <= '0;
      wrapped   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // A pending word survives abort and is only retired by a handshake.
      if (load) begin
        wr_valid <= 1'b1;
        wr_data  <= acc_word;
      end else if (hs) begin
        wr_valid <= 1'b0;
      end
      if (hs) begin
        wr_addr <= wr_addr + RING_BITS'(1);
        if (wr_addr == '1) wrapped <= 1'b1;
      end
      if (drop) overflow <= 1'b1;

      if (abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (arm) begin
              state_q   <= StArmed;
              ptw_q     <= post_trig_words;
              cnt_q     <= '0;
              pend_q    <= 1'b0;
              wr_addr   <= '0;
              trig_addr <= '0;
              trig_lane <= '0;
              wrapped   <= 1'b0;
              overflow  <= 1'b0;
            end
          end
          StArmed: begin
            if (trigger) begin
              // A word still in the register will take wr_addr, so ours lands one past it.
              trig_addr <= wr_addr + RING_BITS'(wr_valid);
              trig_lane <= fill;
              pend_q    <= !load;
              state_q   <= (ptw_q == '0) ? StFlush : StTriggered;
            end
          end
          StTriggered: begin
            if (load) begin
              if (pend_q) begin
                pend_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + PTW_BITS'(1);
                if (cnt_q + PTW_BITS'(1) == ptw_q) state_q <= StFlush;
              end
            end
          end
          StFlush: begin
            if ((fill == 2'd0) && reg_free) state_q <= StDone;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_packer.sv
// Directed bench for la_capture_packer with a scoreboard of expected DRAM words.
module tb_la_capture_packer;

  localparam int RB = 2;
  localparam int PB = 8;

  logic           clk_400mhz = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [63:0]    in_data = '0;
  logic           arm = 1'b0;
  logic           abort = 1'b0;
  logic           trigger = 1'b0;
  logic [PB-1:0]  post_trig_words = '0;
  logic           wr_valid;
  logic           wr_ready = 1'b0;
  logic [RB-1:0]  wr_addr;
  logic [255:0]   wr_data;
  logic           busy;
  logic           done;
  logic [RB-1:0]  trig_addr;
  logic [1:0]     trig_lane;
  logic           wrapped;
  logic           overflow;

  la_capture_packer #(
    .RING_BITS (RB),
    .PTW_BITS  (PB)
  ) dut (
    .clk_400mhz      (clk_400mhz),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .arm             (arm),
    .abort           (abort),
    .trigger         (trigger),
    .post_trig_words (post_trig_words),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .busy            (busy),
    .done            (done),
    .trig_addr       (trig_addr),
    .trig_lane       (trig_lane),
    .wrapped         (wrapped),
    .overflow        (overflow)
  );

  always #5 clk_400mhz = ~clk_400mhz;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [RB-1:0] addr;
    logic [255:0]  data;
  } exp_t;
  exp_t sb[$];

  // Reference packer: lanes, register occupancy and ring index of the next written word.
  logic [63:0] m_lane [3];
  int          m_fill = 0;
  int          m_idx = 0;
  bit          m_full = 0;
  bit          m_acc = 0;
  bit          m_flush = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [255:0] w);
    exp_t e;
    e.addr = RB'(m_idx);
    e.data = w;
    sb.push_back(e);
    m_idx++;
  endtask

  task automatic model_step();
    bit          ofree;
    bit          ld;
    logic [255:0] w;
    ofree = !m_full || wr_ready;
    ld = 0;
    if (arm && !abort) m_idx = 0;
    if (abort) begin
      m_fill = 0;
    end else if (m_acc && in_valid) begin
      if (m_fill == 3) begin
        if (ofree) begin
          push_exp({in_data, m_lane[2], m_lane[1], m_lane[0]});
          ld = 1;
          m_fill = 0;
        end
      end else begin
        m_lane[m_fill] = in_data;
        m_fill++;
      end
    end else if (m_flush && m_fill != 0 && ofree) begin
      w = '0;
      for (int k = 0; k < m_fill; k++) w[k*64 +: 64] = m_lane[k];
      push_exp(w);
      ld = 1;
      m_fill = 0;
    end
    if (ld) m_full = 1;
    else if (m_full && wr_ready) m_full = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_400mhz);
    #1;
    arm = 1'b0;
    abort = 1'b0;
    trigger = 1'b0;
  endtask

  function automatic logic [63:0] rec(input int i);
    return {8'hA5, 24'(i), 32'($urandom)};
  endfunction

  task automatic send(input int i, input bit trg);
    in_valid = 1'b1;
    in_data = rec(i);
    trigger = trg;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  // Output-side checker: pops the scoreboard on each handshake, and checks stall stability.
  bit            hold_prev = 0;
  logic [255:0]  prev_data;
  logic [RB-1:0] prev_addr;
  exp_t          mon_e;
  always @(negedge clk_400mhz) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", wr_valid, 1'b1);
        chk("hold_data", wr_data, prev_data);
        chk("hold_addr", wr_addr, prev_addr);
      end
      if (wr_valid && wr_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL word_expected observed=extra word at addr %0d expected=none", wr_addr);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_data", wr_data, mon_e.data);
        end
      end
      hold_prev = wr_valid && !wr_ready;
      prev_data = wr_data;
      prev_addr = wr_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_400mhz);
    #1;
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_trig_addr", trig_addr, '0);
    chk("rst_trig_lane", trig_lane, '0);
    chk("rst_wrapped", wrapped, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // A: ptw=2, 16 records, trigger with record 5, no stalls
    wr_ready = 1'b1;
    post_trig_words = 8'd2;
    arm = 1'b1;
    tick();
    m_acc = 1;
    chk("a_busy", busy, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(i, i == 5);
      if (i == 5) begin
        chk("a_trig_addr", trig_addr, 2'd1);
        chk("a_trig_lane", trig_lane, 2'd1);
      end
    end
    m_acc = 0;
    wait_done(20);
    chk("a_busy_end", busy, 1'b0);
    chk("a_overflow", overflow, 1'b0);
    chk("a_wrapped", wrapped, 1'b1);
    chk("a_wr_addr", wr_addr, 2'd0);
    chk("a_sb_empty", sb.size(), 0);
    chk("a_trig_stable", trig_addr, 2'd1);

    // B: ptw=0, trigger with record 5 -> trigger word flushed with lanes 2-3 padded
    post_trig_words = 8'd0;
    arm = 1'b1;
    tick();
    m_acc = 1;
    chk("b_done_clr", done, 1'b0);
    for (int i = 0; i < 6; i++) send(i, i == 5);
    m_acc = 0;
    m_flush = 1;
    chk("b_trig_addr", trig_addr, 2'd1);
    chk("b_trig_lane", trig_lane, 2'd1);
    wait_done(20);
    m_flush = 0;
    chk("b_wrapped", wrapped, 1'b0);
    chk("b_wr_addr", wr_addr, 2'd2);
    chk("b_sb_empty", sb.size(), 0);

    // D: abort while a word is stalled; status held, then re-arm clears it
    post_trig_words = 8'd50;
    wr_ready = 1'b0;
    arm = 1'b1;
    tick();
    m_acc = 1;
    for (int i = 0; i < 8; i++) begin
      send(i, i == 5);
      if (i == 5) begin
        chk("d_trig_addr", trig_addr, 2'd1);
        chk("d_trig_lane", trig_lane, 2'd1);
      end
    end
    chk("d_overflow", overflow, 1'b1);
    abort = 1'b1;
    tick();
    m_acc = 0;
    chk("d_busy", busy, 1'b0);
    chk("d_valid_held", wr_valid, 1'b1);
    repeat (3) tick();
    chk("d_valid_held2", wr_valid, 1'b1);
    wr_ready = 1'b1;
    tick();
    chk("d_valid_drained", wr_valid, 1'b0);
    chk("d_wr_addr", wr_addr, 2'd1);
    chk("d_overflow_held", overflow, 1'b1);
    chk("d_trig_held", trig_addr, 2'd1);
    arm = 1'b1;
    tick();
    chk("d_rearm_overflow", overflow, 1'b0);
    chk("d_rearm_wr_addr", wr_addr, 2'd0);
    chk("d_rearm_trig_addr", trig_addr, 2'd0);
    chk("d_rearm_trig_lane", trig_lane, 2'd0);
    chk("d_rearm_busy", busy, 1'b1);
    abort = 1'b1;
    tick();

    // C: 12 stalled cycles under continuous records -> completing records dropped
    arm = 1'b1;
    tick();
    m_acc = 1;
    for (int i = 0; i < 20; i++) begin
      wr_ready = (i >= 12);
      send(i, 1'b0);
      if (i == 6) chk("c_no_overflow_yet", overflow, 1'b0);
    end
    chk("c_overflow", overflow, 1'b1);
    abort = 1'b1;
    tick();
    m_acc = 0;
    repeat (4) tick();
    chk("c_idle", busy, 1'b0);
    chk("c_wr_valid", wr_valid, 1'b0);
    chk("c_wr_addr", wr_addr, 2'd3);
    chk("c_wrapped", wrapped, 1'b0);
    chk("c_sb_empty", sb.size(), 0);

    // E: ring wrap with RING_BITS=2, trigger while a word is pending
    post_trig_words = 8'd0;
    arm = 1'b1;
    tick();
    m_acc = 1;
    for (int i = 0; i < 24; i++) send(i, 1'b0);
    trigger = 1'b1;
    tick();
    m_acc = 0;
    m_flush = 1;
    chk("e_trig_addr", trig_addr, 2'd2);
    chk("e_trig_lane", trig_lane, 2'd0);
    chk("e_wrapped", wrapped, 1'b1);
    wait_done(20);
    m_flush = 0;
    chk("e_wr_addr", wr_addr, 2'd2);
    chk("e_sb_empty", sb.size(), 0);

    // F: asynchronous reset in the middle of TRIGGERED
    post_trig_words = 8'd50;
    wr_ready = 1'b0;
    arm = 1'b1;
    tick();
    m_acc = 1;
    for (int i = 0; i < 6; i++) send(i, i == 2);
    chk("f_busy", busy, 1'b1);
    chk("f_valid", wr_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_wr_valid", wr_valid, 1'b0);
    chk("f_wr_data", wr_data, '0);
    chk("f_busy_rst", busy, 1'b0);
    chk("f_done", done, 1'b0);
    chk("f_trig_lane", trig_lane, '0);
    chk("f_trig_addr", trig_addr, '0);
    chk("f_overflow", overflow, 1'b0);
    sb.delete();
    m_fill = 0;
    m_full = 0;
    m_acc = 0;
    @(posedge clk_400mhz);
    #1;
    rst_n = 1'b1;
    tick();
    chk("f_idle_after", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
